// File: rtl/result_uart_pkg.sv
// Shared types and constants for the result-word UART transmitter.
package result_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Wide enough to index 8 data bits and up to 2 stop bits.
  localparam int unsigned BIT_CNT_W  = 3;
  // Baud counter covers CLK_DIV up to 65535.
  localparam int unsigned BAUD_CNT_W = 16;
  localparam logic        TX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: loads CLK_DIV-1 on restart and counts down to 0.
// bit_tick is high on the last cycle of the current bit period.
module uart_baud_gen
  import result_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  logic [BAUD_CNT_W-1:0] cnt;

  // Down-counter, reloaded at every bit entry, parks at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= BAUD_CNT_W'(CLK_DIV - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bit_tick = (cnt == '0);

endmodule

// File: rtl/result_uart_tx.sv
// Result-word UART transmitter: valid/ready input, 8N1/8E1 (1 or 2 stop
// bits) serial output on a registered, glitch-free tx line.
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("result_uart_tx: CLK_DIV must be in 2..65535");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("result_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN > 1) begin : g_bad_parity_en
    $error("result_uart_tx: PARITY_EN must be 0 or 1");
  end

  state_t                 state, state_nxt;
  logic                   tx_q, tx_nxt;
  logic [7:0]             shift, shift_nxt;
  logic                   par, par_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt, cnt_nxt;
  logic                   run;
  logic                   restart;
  logic                   bit_tick;
  logic                   xfer;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bit_tick(bit_tick)
  );

  // run is a one-flop out-of-reset flag so in_ready stays low while rst_n
  // is asserted and rises on the first edge after release.
  assign in_ready = ena && (state == IDLE) && run;
  assign xfer     = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign tx       = tx_q;

  // State, shift register, parity and registered tx line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_q    <= TX_IDLE_LVL;
      shift   <= '0;
      par     <= 1'b0;
      bit_cnt <= '0;
      run     <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_q    <= tx_nxt;
      shift   <= shift_nxt;
      par     <= par_nxt;
      bit_cnt <= cnt_nxt;
      run     <= 1'b1;
    end
  end

  // Next-state logic; tx is computed one bit ahead so the register drives
  // each bit from its first cycle.
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_q;
    shift_nxt = shift;
    par_nxt   = par;
    cnt_nxt   = bit_cnt;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = TX_IDLE_LVL;
        if (xfer) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
          shift_nxt = in_data;
          par_nxt   = ^in_data;
          cnt_nxt   = '0;
          restart   = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_nxt = DATA;
          tx_nxt    = shift[0];
          shift_nxt = {1'b0, shift[7:1]};
          cnt_nxt   = '0;
          restart   = 1'b1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          restart = 1'b1;
          if (bit_cnt == BIT_CNT_W'(7)) begin
            cnt_nxt = '0;
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
              tx_nxt    = par;
            end else begin
              state_nxt = STOP;
              tx_nxt    = TX_IDLE_LVL;
            end
          end else begin
            cnt_nxt   = bit_cnt + 1'b1;
            tx_nxt    = shift[0];
            shift_nxt = {1'b0, shift[7:1]};
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_nxt = STOP;
          tx_nxt    = TX_IDLE_LVL;
          cnt_nxt   = '0;
          restart   = 1'b1;
        end
      end
      STOP: begin
        tx_nxt = TX_IDLE_LVL;
        if (bit_tick) begin
          if (bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
            restart = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = TX_IDLE_LVL;
      end
    endcase
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: table of frames plus hand-written
// back-to-back, ignored-pulse, mid-frame reset and ena-drop sequences.
module tb_result_uart_tx;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena0, ena1;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       tx0, tx1;
  logic       busy0, busy1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_uart_tx #(.CLK_DIV(DIV), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena0), .in_data(data0), .in_valid(valid0),
    .in_ready(ready0), .tx(tx0), .busy(busy0)
  );

  result_uart_tx #(.CLK_DIV(DIV), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .in_data(data1), .in_valid(valid1),
    .in_ready(ready1), .tx(tx1), .busy(busy1)
  );

  // Expected line levels written in transmission order, left to right,
  // padded with idle 1s to 12 bits.
  typedef struct {
    logic        sel;
    logic [7:0]  data;
    logic [11:0] bits;
    int          nbits;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input logic s);
    return s ? tx1 : tx0;
  endfunction

  function automatic logic get_ready(input logic s);
    return s ? ready1 : ready0;
  endfunction

  function automatic logic get_busy(input logic s);
    return s ? busy1 : busy0;
  endfunction

  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    if (s) begin valid1 = v; data1 = d; end
    else   begin valid0 = v; data0 = d; end
  endtask

  task automatic set_ena(input logic s, input logic e);
    if (s) ena1 = e;
    else   ena0 = e;
  endtask

  // Called at the negedge of frame cycle 1; returns at the negedge of the
  // first cycle after the frame.
  task automatic check_frame(input logic s, input logic [11:0] bits, input int nbits,
                             input string name, input int pulse_at, input int drop_at,
                             input logic rdy_end);
    logic bad_ctl;
    int   idx;
    bad_ctl = 1'b0;
    for (int c = 1; c <= nbits * DIV; c++) begin
      idx = (c - 1) / DIV;
      check($sformatf("%s_tx_c%0d", name, c), get_tx(s), bits[11 - idx]);
      if (get_busy(s) !== 1'b1 || get_ready(s) !== 1'b0) bad_ctl = 1'b1;
      if (c == pulse_at)     drive(s, 1'b1, 8'hFF);
      if (c == pulse_at + 1) drive(s, 1'b0, 8'hFF);
      if (c == drop_at)      set_ena(s, 1'b0);
      @(negedge clk);
    end
    check($sformatf("%s_busy_ready_in_frame", name), bad_ctl, 1'b0);
    check($sformatf("%s_end_busy", name), get_busy(s), 1'b0);
    check($sformatf("%s_end_tx", name), get_tx(s), 1'b1);
    check($sformatf("%s_end_ready", name), get_ready(s), rdy_end);
  endtask

  task automatic wait_ready(input logic s, input string name);
    int n;
    n = 0;
    while (get_ready(s) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_ready_pre", name), get_ready(s), 1'b1);
  endtask

  task automatic send(input logic s, input logic [7:0] d, input logic [11:0] bits,
                      input int nbits, input string name, input int pulse_at,
                      input int drop_at, input logic rdy_end);
    wait_ready(s, name);
    drive(s, 1'b1, d);
    @(negedge clk);
    drive(s, 1'b0, ~d);
    check_frame(s, bits, nbits, name, pulse_at, drop_at, rdy_end);
  endtask

  initial begin
    logic bad;

    vecs[0] = '{1'b0, 8'hA5, 12'b0101_0010_1111, 10, "a5_p0"};
    vecs[1] = '{1'b1, 8'h07, 12'b0111_0000_0111, 11, "07_p1"};
    vecs[2] = '{1'b1, 8'h03, 12'b0110_0000_0011, 11, "03_p1"};
    vecs[3] = '{1'b0, 8'h00, 12'b0000_0000_0111, 10, "00_p0"};
    vecs[4] = '{1'b1, 8'hFF, 12'b0111_1111_1011, 11, "ff_p1"};
    vecs[5] = '{1'b0, 8'h80, 12'b0000_0000_1111, 10, "80_p0"};
    vecs[6] = '{1'b1, 8'h01, 12'b0100_0000_0111, 11, "01_p1"};

    rst_n  = 1'b0;
    ena0   = 1'b1;  ena1   = 1'b1;
    valid0 = 1'b0;  valid1 = 1'b0;
    data0  = 8'h00; data1  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx0", tx0, 1'b1);
    check("rst_busy0", busy0, 1'b0);
    check("rst_ready0", ready0, 1'b0);
    check("rst_tx1", tx1, 1'b1);
    check("rst_ready1", ready1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready0", ready0, 1'b1);
    check("rel_ready1", ready1, 1'b1);

    // Table of single frames
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].sel, vecs[i].data, vecs[i].bits, vecs[i].nbits, vecs[i].name, -1, -1, 1'b1);
    end

    // Back-to-back with in_valid held high
    wait_ready(1'b0, "b2b");
    drive(1'b0, 1'b1, 8'h11);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h22);
    check_frame(1'b0, 12'b0100_0100_0111, 10, "b2b_11", -1, -1, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    check_frame(1'b0, 12'b0010_0010_0111, 10, "b2b_22", -1, -1, 1'b1);

    // in_valid pulse mid-frame is ignored
    send(1'b0, 8'h5A, 12'b0010_1101_0111, 10, "ign", 9, -1, 1'b1);
    bad = 1'b0;
    repeat (8) begin
      if (busy0 !== 1'b0 || tx0 !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    check("ign_no_extra_frame", bad, 1'b0);

    // Reset during DATA bit 3 (frame cycle 18)
    wait_ready(1'b0, "midrst");
    drive(1'b0, 1'b1, 8'hA5);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    repeat (17) @(negedge clk);
    check("midrst_pre_tx", tx0, 1'b0);
    check("midrst_pre_busy", busy0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx0, 1'b1);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_ready", ready0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || tx0 !== 1'b1) bad = 1'b1;
    end
    check("midrst_no_resume", bad, 1'b0);
    check("midrst_ready_after", ready0, 1'b1);

    // ena dropped mid-frame: frame completes, no new word accepted
    send(1'b1, 8'h07, 12'b0111_0000_0111, 11, "ena_drop", -1, 10, 1'b0);
    drive(1'b1, 1'b1, 8'h33);
    bad = 1'b0;
    repeat (10) begin
      if (busy1 !== 1'b0 || ready1 !== 1'b0 || tx1 !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    check("ena_drop_hold_idle", bad, 1'b0);
    drive(1'b1, 1'b0, 8'h00);
    set_ena(1'b1, 1'b1);
    #1;
    check("ena_restore_ready", ready1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
